if_fetch_stage: RTL and testbench

- Instruction-fetch stage between the program counter and decode.
- Takes the current PC, runs a req/ack handshake with instruction memory, and computes the next PC (PC+4 or redirect target). It drives the PC's write enable and next address.
- Holds the IF/ID pipeline register, with a one-entry skid buffer, stall from the hazard unit and flush on branch/jump redirect.

---
 rtl/if_fetch_stage.sv | 146 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC sequencing, instruction-memory req/ack handshake,
// and the IF/ID pipeline register backed by a one-entry skid buffer.
module if_fetch_stage #(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_we,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               ifid_valid,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr
);

    localparam logic [1:0]        ST_IDLE    = 2'd0;
    localparam logic [1:0]        ST_FETCH   = 2'd1;
    localparam logic [1:0]        ST_DRAIN   = 2'd2;
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(32'd4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(32'd3);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_req_pending;
    logic [ADDR_W-1:0]  r_req_addr;
    logic               r_buf_valid;
    logic [ADDR_W-1:0]  r_buf_pc;
    logic [INSTR_W-1:0] r_buf_instr;
    logic               r_ifid_valid;
    logic [ADDR_W-1:0]  r_ifid_pc;
    logic [INSTR_W-1:0] r_ifid_instr;
    logic               w_can_accept;
    logic               w_req;
    logic               w_req_open;
    logic               w_accept;

    // Request generation and response acceptance
    always_comb begin
        w_can_accept = !r_buf_valid && (!r_ifid_valid || !stall);
        w_req        = 1'b0;
        case (r_state)
            ST_FETCH: w_req = r_req_pending || w_can_accept;
            ST_DRAIN: w_req = 1'b1;
            default:  w_req = 1'b0;
        endcase
        // A request left open past this cycle must be held, even across a redirect.
        w_req_open = w_req && !imem_ack;
        w_accept   = (r_state == ST_FETCH) && w_req && imem_ack && !redirect;
    end

    // Next-PC selection towards the program counter
    always_comb begin
        pc_we   = 1'b0;
        pc_next = pc_in;
        if (!rst) begin
            pc_we   = 1'b0;
            pc_next = pc_in;
        end else if (redirect) begin
            pc_we   = 1'b1;
            pc_next = redirect_target & ALIGN_MASK;
        end else if (w_accept) begin
            pc_we   = 1'b1;
            pc_next = pc_in + PC_STEP;
        end else begin
            pc_we   = 1'b0;
            pc_next = pc_in;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_FETCH;
            ST_FETCH: w_state_nxt = (redirect && w_req_open) ? ST_DRAIN : ST_FETCH;
            ST_DRAIN: w_state_nxt = w_req_open ? ST_DRAIN : ST_FETCH;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign imem_req   = w_req;
    // The address is frozen while a request is open so a redirected PC cannot disturb it.
    assign imem_addr  = r_req_pending ? r_req_addr : pc_in;
    assign ifid_valid = r_ifid_valid;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_instr;

    // State and outstanding-request tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_req_pending <= 1'b0;
            r_req_addr    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_req_pending <= w_req_open;
            if (w_req_open && !r_req_pending) begin
                r_req_addr <= pc_in;
            end
        end
    end

    // IF/ID register and skid buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_buf_valid  <= 1'b0;
            r_buf_pc     <= '0;
            r_buf_instr  <= NOP_INSTR;
        end else if (redirect) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
            r_buf_valid  <= 1'b0;
        end else if (stall && r_ifid_valid) begin
            if (w_accept) begin
                r_buf_valid <= 1'b1;
                r_buf_pc    <= pc_in;
                r_buf_instr <= imem_rdata;
            end
        end else if (r_buf_valid) begin
            r_ifid_valid <= 1'b1;
            r_ifid_pc    <= r_buf_pc;
            r_ifid_instr <= r_buf_instr;
            r_buf_valid  <= 1'b0;
        end else if (w_accept) begin
            r_ifid_valid <= 1'b1;
            r_ifid_pc    <= pc_in;
            r_ifid_instr <= imem_rdata;
        end else begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: bench-side PC register, latency-programmable memory,
// and a queue of accepted-but-unconsumed instructions as the reference.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;

    int          total = 0;
    int          bad = 0;
    int          accepts = 0;
    ent_t        q[$];
    logic        busy;
    logic        stale;
    logic        idle;
    int          cnt;
    int unsigned lat_lo;
    int unsigned lat_hi;
    int unsigned spur_pct;
    logic [31:0] maddr;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_we(pc_we), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .ifid_valid(ifid_valid),
        .ifid_pc(ifid_pc), .ifid_instr(ifid_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[17:2] | 16'h8000};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
        logic        exp_req, acc, exp_we, req_s, ack_s;
        logic [31:0] exp_next, rdata_s;
        ent_t        e;
        stall = st; redirect = rd; redirect_target = tgt; imem_ack = 1'b0;
        #1;
        exp_req = !idle && (busy || (q.size() < 2 && (q.size() == 0 || !st)));
        check("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        check("ifid_valid", {31'd0, ifid_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
        if (q.size() > 0) begin
            check("ifid_pc", ifid_pc, q[0].pc);
            check("ifid_instr", ifid_instr, q[0].instr);
        end else begin
            check("ifid_nop", ifid_instr, NOP);
        end
        if (imem_req) begin
            if (!busy) begin
                check("new_addr", imem_addr, pc_in);
                busy = 1'b1; maddr = imem_addr; cnt = int'($urandom_range(lat_hi, lat_lo));
            end else begin
                check("addr_hold", imem_addr, maddr);
            end
            if (cnt == 0) begin
                imem_ack = 1'b1; imem_rdata = mem_word(maddr);
            end else begin
                cnt--; imem_rdata = $urandom;
            end
        end else begin
            imem_ack = ($urandom_range(32'd99, 32'd0) < spur_pct); imem_rdata = $urandom;
        end
        #1;
        acc      = imem_req && imem_ack && !rd && !stale;
        exp_we   = rd || acc;
        exp_next = rd ? {tgt[31:2], 2'b00} : (acc ? pc_in + 32'd4 : pc_in);
        check("pc_we", {31'd0, pc_we}, {31'd0, exp_we});
        check("pc_next", pc_next, exp_next);
        req_s = imem_req; ack_s = imem_ack; rdata_s = imem_rdata;
        @(posedge clk); #1;
        if (rd) begin
            q.delete();
        end else begin
            if (q.size() > 0 && !st) void'(q.pop_front());
            if (acc) begin
                e.pc = pc_in; e.instr = rdata_s; q.push_back(e); accepts++;
            end
        end
        if (req_s && ack_s) begin
            busy = 1'b0; stale = 1'b0;
        end else if (rd && busy) begin
            stale = 1'b1;
        end
        if (exp_we) pc_in = exp_next;
        imem_ack = 1'b0; idle = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] pc0);
        rst = 1'b0; pc_in = pc0; stall = 1'b0; redirect = 1'b1; redirect_target = 32'h0000_7774;
        imem_ack = 1'b0; imem_rdata = 32'h0; busy = 1'b0; stale = 1'b0; idle = 1'b1; q.delete();
        @(negedge clk); #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, ifid_valid}, 32'd0);
        check("rst_ifid_pc", ifid_pc, 32'd0);
        check("rst_ifid_instr", ifid_instr, NOP);
        check("rst_pc_we", {31'd0, pc_we}, 32'd0);
        check("rst_pc_next", pc_next, pc_in);
        redirect = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; spur_pct = 0; lat_lo = 0; lat_hi = 0;
        do_reset(32'h0000_1000);
        // zero-wait: IDLE cycle then one fetch per cycle
        repeat (4) step(1'b0, 1'b0, 32'h0);
        check("b2b_pc", pc_in, 32'h0000_100C);
        // three-cycle ack latency
        lat_lo = 2; lat_hi = 2;
        repeat (3) step(1'b0, 1'b0, 32'h0);
        check("lat_pc", pc_in, 32'h0000_1010);
        // redirect over an outstanding request, late ack discarded
        lat_lo = 3; lat_hi = 3;
        step(1'b0, 1'b0, 32'h0);
        lat_lo = 0; lat_hi = 0;
        step(1'b0, 1'b1, 32'h0000_2003);
        check("redir_target", pc_in, 32'h0000_2000);
        repeat (4) step(1'b0, 1'b0, 32'h0);
        check("redir_pc", pc_in, 32'h0000_2008);
        // redirect, stall and ack together
        lat_lo = 1; lat_hi = 1;
        step(1'b0, 1'b0, 32'h0);
        lat_lo = 0; lat_hi = 0;
        step(1'b1, 1'b1, 32'h0000_3005);
        step(1'b0, 1'b0, 32'h0);
        check("flush_pc", pc_in, 32'h0000_3008);
        // PC wrap-around
        do_reset(32'hFFFF_FFF8);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        check("wrap_pc", pc_in, 32'h0000_0000);
        step(1'b0, 1'b0, 32'h0);
        // asynchronous reset while waiting on memory
        lat_lo = 3; lat_hi = 3;
        repeat (2) step(1'b0, 1'b0, 32'h0);
        #3 rst = 1'b0;
        #1;
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_valid", {31'd0, ifid_valid}, 32'd0);
        check("arst_pc_we", {31'd0, pc_we}, 32'd0);
        do_reset(32'h0000_4000);
        // redirect during IDLE
        lat_lo = 0; lat_hi = 0;
        step(1'b0, 1'b1, 32'h0000_5002);
        step(1'b0, 1'b0, 32'h0);
        check("idle_redir_pc", pc_in, 32'h0000_5004);
        // randomized traffic
        spur_pct = 20; lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(32'd9, 32'd0) < 32'd3, $urandom_range(32'd19, 32'd0) == 32'd0, $urandom);
        end
        check("liveness", (accepts > 300) ? 32'd1 : 32'd0, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
